axi_adder: RTL and testbench
============================

# axi_adder

AXI4-Lite slave peripheral that adds two 32-bit operands on software command. The CPU writes operands A and B, starts the operation through a control register, polls a status register for completion, then reads the 32-bit sum. It sits on the PS-to-PL AXI4-Lite control bus as a single memory-mapped register block.

## Interface
- C_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_AXI_ADDR_WIDTH, 32: AXI address width; only bits [4:2] are decoded.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-low.
- axi_aclk  in  1  clock.
- axi_aresetn  in  1  synchronous active-low reset.
- axi_awaddr  in  C_AXI_ADDR_WIDTH  write address.
- axi_awvalid / axi_awready  in / out  1  write-address handshake.
- axi_wdata  in  32  write data.
- axi_wstrb  in  4  byte enables.
- axi_wvalid / axi_wready  in / out  1  write-data handshake.
- axi_bresp  out  2  write response, always 2'b00 (OKAY).
- axi_bvalid / axi_bready  out / in  1  write-response handshake.
- axi_araddr  in  C_AXI_ADDR_WIDTH  read address.
- axi_arvalid / axi_arready  in / out  1  read-address handshake.
- axi_rdata  out  32  read data.
- axi_rresp  out  2  always 2'b00.
- axi_rvalid / axi_rready  out / in  1  read-data handshake.

## Operation
- Register map:
  - 0x00 A (RW).
  - 0x04 B (RW).
  - 0x08 CTRL (RW).
  - 0x0C STAT (RO).
  - 0x10 RES (RO).
  - Other offsets read 0; writes to them and to STAT or RES are ignored, but still return OKAY.
- Writes honour axi_wstrb per byte.
- Any write to CTRL stores the value. If the stored value is nonzero, the write is a start:
  - A and B are latched into the core.
  - STAT is cleared to 0.
- A write of 0 to CTRL only clears STAT.
- Result: RES = (A + B) mod 2^32. Carry is discarded, so 0xFFFFFFFF + 1 = 0, and 0xFFFFFFF6 + 5 = 0xFFFFFFFB.
- STAT reads 0xFFFFFFFF when a result is valid and 0x00000000 when idle or busy.
- Writing A or B while busy does not affect the in-flight sum. The new values are used at the next start.

## Timing
- Reset values:
  - awready, wready, bvalid, arready and rvalid are 0.
  - bresp, rresp and rdata are 0.
  - A, B, CTRL, STAT and RES are all 0.
- Write path:
  - A write is accepted only when awvalid and wvalid are both high and bvalid is low.
  - awready and wready pulse together for exactly one cycle.
  - The register updates on that edge.
  - bvalid rises on the next cycle and holds until bready is sampled high.
- Read path:
  - arready pulses for one cycle when arvalid is high and rvalid is low.
  - The address is latched on that edge.
  - rvalid and rdata appear on the next cycle.
  - rdata is held stable until rready is sampled high.
- Read and write channels are independent. A STAT read accepted in the same cycle as a start write returns the pre-write STAT.
- Compute latency: STAT becomes 0xFFFFFFFF and RES is valid 2 cycles after the start write is accepted.
- A second start while busy restarts the operation with the newly latched operands.
- Reset asserted mid-operation aborts it, and all state returns to reset values.

## Structure
- Shared package `axi_adder_pkg` holds:
  - register offsets: ADDR_REG_A, ADDR_REG_B, ADDR_REG_CTRL, ADDR_REG_STAT, ADDR_REG_RES;
  - RESP_OKAY;
  - STAT_DONE = 32'hFFFFFFFF;
  - COMPUTE_LATENCY = 2.
- One sub-module, `adder_core`, contains:
  - the start-pulse input;
  - operand latches;
  - the 2-stage done pipeline;
  - the 32-bit sum output and the done flag.
- The top level contains the AXI4-Lite slave FSM and the register file.

## Test plan
- Reset, then read all five registers -> every read returns 0, and both bresp and rresp are OKAY.
- Write A=10, B=20; read back -> 10 and 20. Write CTRL=0xFFFFFFFF, poll STAT until 0xFFFFFFFF within 1000 polls -> RES=30.
- A=100, B=200, start -> RES=300; CTRL reads back 0xFFFFFFFF.
- A=0xFFFFFFFF, B=1, start -> RES=0.
- A=0xFFFFFFF6, B=5, start -> RES=0xFFFFFFFB.
- Stress the protocol:
  - Write B with wstrb=4'b0001 -> only byte 0 changes.
  - Read STAT immediately after a start -> 0.
  - Hold bready and rready low for 5 cycles -> bvalid and rvalid stay high with stable data.
  - Read offset 0x14 -> 0.

Source files
------------

// File: rtl/axi_adder_pkg.sv
// axi_adder_pkg: shared constants and types for the AXI4-Lite adder block.
//   - Register word indices (address bits [4:2]) for A, B, CTRL, STAT, RES.
//   - AXI response code, STAT "done" pattern and the compute latency.
//   - Write/read channel FSM state types and a byte-strobe merge helper.
package axi_adder_pkg;

  localparam logic [2:0]  ADDR_REG_A    = 3'd0;  // 0x00
  localparam logic [2:0]  ADDR_REG_B    = 3'd1;  // 0x04
  localparam logic [2:0]  ADDR_REG_CTRL = 3'd2;  // 0x08
  localparam logic [2:0]  ADDR_REG_STAT = 3'd3;  // 0x0C
  localparam logic [2:0]  ADDR_REG_RES  = 3'd4;  // 0x10

  localparam logic [1:0]  RESP_OKAY     = 2'b00;
  localparam logic [31:0] STAT_DONE     = 32'hFFFF_FFFF;

  // Cycles from the accepted start write until STAT/RES are valid.
  localparam int          COMPUTE_LATENCY = 2;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rd_state_t;

  // Merge new write data into an old register value under byte strobes.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++)
      if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/axi_adder_core.sv
// adder_core: operand latch + fixed-latency done pipeline for the adder.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : one-cycle pulse; latches a/b and (re)starts the operation
//   clear      : one-cycle pulse; drops the done flag only
//   a, b       : operands sampled on start
//   sum        : (a + b) mod 2^32, held until the next completion
//   done       : high from completion until the next start/clear
module adder_core
  import axi_adder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clear,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        done
);

  // Stage 0 is the start pulse itself; the last stage's edge publishes the
  // result so it is visible COMPUTE_LATENCY cycles after the start edge.
  localparam int STAGES = COMPUTE_LATENCY - 1;

  logic [31:0]     op_a, op_b;
  logic [STAGES:0] vld_pipe;

  assign vld_pipe[0] = start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a              <= '0;
      op_b              <= '0;
      sum               <= '0;
      done              <= 1'b0;
      vld_pipe[STAGES:1] <= '0;
    end else begin
      if (start) begin
        op_a <= a;
        op_b <= b;
        // A restart flushes any in-flight token so stale operands never complete.
        vld_pipe[STAGES:1] <= STAGES'(1);
        done <= 1'b0;
      end else begin
        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
        if (vld_pipe[STAGES]) begin
          sum  <= op_a + op_b;  // carry intentionally dropped
          done <= 1'b1;
        end else if (clear) begin
          done <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/axi_adder.sv
// axi_adder: AXI4-Lite slave register block wrapping adder_core.
//   Registers (addr[4:2]): A(RW) B(RW) CTRL(RW) STAT(RO) RES(RO); others read 0.
//   Nonzero CTRL write starts an add of A+B; zero CTRL write clears STAT.
//   axi_aclk/axi_aresetn : clock, synchronous active-low reset
//   aw/w/b channels      : single-beat writes, one outstanding, bresp OKAY
//   ar/r channels        : single-beat reads, one outstanding, rresp OKAY
module axi_adder
  import axi_adder_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 32
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic                          axi_awvalid,
  output logic                          axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                          axi_wvalid,
  output logic                          axi_wready,
  output logic [1:0]                    axi_bresp,
  output logic                          axi_bvalid,
  input  logic                          axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic                          axi_arvalid,
  output logic                          axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]                    axi_rresp,
  output logic                          axi_rvalid,
  input  logic                          axi_rready
);

  wr_state_t   wr_state;
  rd_state_t   rd_state;

  logic [31:0] reg_a, reg_b, reg_ctrl;
  logic [31:0] core_sum;
  logic        core_done;

  logic [2:0]  wr_idx, rd_idx;
  logic        wr_en;
  logic [31:0] ctrl_next;
  logic        start, clear;
  logic [31:0] rd_mux;

  assign wr_idx = axi_awaddr[4:2];
  assign rd_idx = axi_araddr[4:2];

  // The write lands on the edge where awready/wready are high (state W_ACK).
  assign wr_en     = (wr_state == W_ACK);
  assign ctrl_next = apply_wstrb(reg_ctrl, axi_wdata, axi_wstrb);
  assign start     = wr_en && (wr_idx == ADDR_REG_CTRL) && (ctrl_next != '0);
  assign clear     = wr_en && (wr_idx == ADDR_REG_CTRL) && (ctrl_next == '0);

  // ---------------- write channel FSM ----------------
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      wr_state    <= W_IDLE;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: if (axi_awvalid && axi_wvalid && !axi_bvalid) begin
          axi_awready <= 1'b1;
          axi_wready  <= 1'b1;
          wr_state    <= W_ACK;
        end
        W_ACK: begin
          axi_awready <= 1'b0;
          axi_wready  <= 1'b0;
          axi_bvalid  <= 1'b1;
          axi_bresp   <= RESP_OKAY;
          wr_state    <= W_RESP;
        end
        W_RESP: if (axi_bready) begin
          axi_bvalid <= 1'b0;
          wr_state   <= W_IDLE;
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- register file ----------------
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      reg_a    <= '0;
      reg_b    <= '0;
      reg_ctrl <= '0;
    end else if (wr_en) begin
      case (wr_idx)
        ADDR_REG_A:    reg_a    <= apply_wstrb(reg_a, axi_wdata, axi_wstrb);
        ADDR_REG_B:    reg_b    <= apply_wstrb(reg_b, axi_wdata, axi_wstrb);
        ADDR_REG_CTRL: reg_ctrl <= ctrl_next;
        default: ;  // STAT, RES and unmapped offsets are write-ignored
      endcase
    end
  end

  // ---------------- read channel FSM ----------------
  always_comb begin
    rd_mux = '0;
    case (rd_idx)
      ADDR_REG_A:    rd_mux = reg_a;
      ADDR_REG_B:    rd_mux = reg_b;
      ADDR_REG_CTRL: rd_mux = reg_ctrl;
      ADDR_REG_STAT: rd_mux = core_done ? STAT_DONE : '0;
      ADDR_REG_RES:  rd_mux = core_sum;
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      rd_state    <= R_IDLE;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rdata   <= '0;
      axi_rresp   <= RESP_OKAY;
    end else begin
      case (rd_state)
        R_IDLE: if (axi_arvalid && !axi_rvalid) begin
          axi_arready <= 1'b1;
          rd_state    <= R_ACK;
        end
        R_ACK: begin
          // Capture at the accept edge: a concurrent start write is not yet visible.
          axi_arready <= 1'b0;
          axi_rdata   <= rd_mux;
          axi_rresp   <= RESP_OKAY;
          axi_rvalid  <= 1'b1;
          rd_state    <= R_DATA;
        end
        R_DATA: if (axi_rready) begin
          axi_rvalid <= 1'b0;
          rd_state   <= R_IDLE;
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  adder_core u_core (
    .clk   (axi_aclk),
    .rst_n (axi_aresetn),
    .start (start),
    .clear (clear),
    .a     (reg_a),
    .b     (reg_b),
    .sum   (core_sum),
    .done  (core_done)
  );

endmodule

// File: tb/tb_axi_adder.sv
// Directed, table-driven bench for axi_adder.
module tb_axi_adder;

  localparam logic [31:0] A_OFF = 32'h00, B_OFF = 32'h04, C_OFF = 32'h08,
                          S_OFF = 32'h0C, R_OFF = 32'h10, X_OFF = 32'h14;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axi_adder dut (
    .axi_aclk(clk), .axi_aresetn(aresetn),
    .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // hold = cycles bready stays low after bvalid, checking bvalid/bresp stay put.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold);
    int n;
    logic ok;
    @(posedge clk); #1;
    awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(awready && wready) && n < 100) begin @(negedge clk); n++; end
    if (!(awready && wready)) timeout("aw/w handshake");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 100) begin @(negedge clk); n++; end
    if (!bvalid) timeout("bvalid");
    check("bresp", {30'd0, bresp}, 32'd0);
    if (hold > 0) begin
      ok = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!bvalid || bresp !== 2'b00) ok = 1'b0;
      end
      check("bvalid held while bready low", {31'd0, ok}, 32'd1);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, input int hold);
    int n;
    logic ok;
    logic [31:0] first;
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 100) begin @(negedge clk); n++; end
    if (!arready) timeout("arready");
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 100) begin @(negedge clk); n++; end
    if (!rvalid) timeout("rvalid");
    data = rdata;
    check("rresp", {30'd0, rresp}, 32'd0);
    if (hold > 0) begin
      ok = 1'b1;
      first = rdata;
      repeat (hold) begin
        @(negedge clk);
        if (!rvalid || rdata !== first) ok = 1'b0;
      end
      check("rvalid/rdata held while rready low", {31'd0, ok}, 32'd1);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic poll_done(input string name);
    logic [31:0] s;
    int n;
    n = 0;
    s = '0;
    while (s !== 32'hFFFF_FFFF && n < 1000) begin
      axi_read(S_OFF, s, 0);
      n++;
    end
    if (s !== 32'hFFFF_FFFF) timeout(name);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;

  vec_t vecs[5];
  logic [31:0] d;

  initial begin
    vecs[0] = '{32'd10,         32'd20,         32'd30};
    vecs[1] = '{32'd100,        32'd200,        32'd300};
    vecs[2] = '{32'hFFFF_FFFF,  32'd1,          32'h0000_0000};
    vecs[3] = '{32'hFFFF_FFF6,  32'd5,          32'hFFFF_FFFB};
    vecs[4] = '{32'h1234_5678,  32'h1111_1111,  32'h2345_6789};

    repeat (4) @(posedge clk);
    #1 aresetn = 1'b1;

    // Reset state of outputs and registers.
    @(negedge clk);
    check("reset bvalid/rvalid/ready", {27'd0, awready, wready, bvalid, arready, rvalid}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    axi_read(A_OFF, d, 0); check("reset A", d, 32'd0);
    axi_read(B_OFF, d, 0); check("reset B", d, 32'd0);
    axi_read(C_OFF, d, 0); check("reset CTRL", d, 32'd0);
    axi_read(S_OFF, d, 0); check("reset STAT", d, 32'd0);
    axi_read(R_OFF, d, 0); check("reset RES", d, 32'd0);

    // Table: program operands, read back, start, poll, check sum and CTRL.
    for (int i = 0; i < 5; i++) begin
      axi_write(A_OFF, vecs[i].a, 4'hF, 0);
      axi_write(B_OFF, vecs[i].b, 4'hF, 0);
      axi_read(A_OFF, d, 0); check($sformatf("vec%0d A readback", i), d, vecs[i].a);
      axi_read(B_OFF, d, 0); check($sformatf("vec%0d B readback", i), d, vecs[i].b);
      axi_write(C_OFF, 32'hFFFF_FFFF, 4'hF, 0);
      poll_done($sformatf("vec%0d poll STAT", i));
      axi_read(R_OFF, d, 0); check($sformatf("vec%0d RES", i), d, vecs[i].sum);
      axi_read(C_OFF, d, 0); check($sformatf("vec%0d CTRL readback", i), d, 32'hFFFF_FFFF);
    end

    // Byte strobes: only byte 0 of B changes.
    axi_write(B_OFF, 32'h1122_3344, 4'hF, 0);
    axi_write(B_OFF, 32'hAABB_CCDD, 4'b0001, 0);
    axi_read(B_OFF, d, 0); check("B wstrb byte0", d, 32'h1122_33DD);

    // CTRL=0 clears STAT and stores 0.
    axi_write(C_OFF, 32'h0, 4'hF, 0);
    axi_read(S_OFF, d, 0); check("STAT after CTRL=0", d, 32'd0);
    axi_read(C_OFF, d, 0); check("CTRL after CTRL=0", d, 32'd0);

    // STAT read accepted in the same cycle as a start returns the pre-write 0.
    axi_write(A_OFF, 32'd1, 4'hF, 0);
    axi_write(B_OFF, 32'd2, 4'hF, 0);
    fork
      axi_write(C_OFF, 32'd1, 4'hF, 0);
      axi_read(S_OFF, d, 0);
    join
    check("STAT right at start", d, 32'd0);
    poll_done("poll STAT 1+2");
    axi_read(R_OFF, d, 0); check("RES 1+2", d, 32'd3);

    // New A only takes effect at the next start.
    axi_write(A_OFF, 32'd50, 4'hF, 0);
    axi_read(R_OFF, d, 0); check("RES unchanged by A write", d, 32'd3);
    axi_read(S_OFF, d, 0); check("STAT unchanged by A write", d, 32'hFFFF_FFFF);
    axi_write(C_OFF, 32'd1, 4'hF, 0);
    poll_done("poll STAT 50+2");
    axi_read(R_OFF, d, 0); check("RES 50+2", d, 32'd52);

    // Writes to STAT/RES are ignored.
    axi_write(R_OFF, 32'hDEAD_BEEF, 4'hF, 0);
    axi_write(S_OFF, 32'h0, 4'hF, 0);
    axi_read(R_OFF, d, 0); check("RES write ignored", d, 32'd52);
    axi_read(S_OFF, d, 0); check("STAT write ignored", d, 32'hFFFF_FFFF);

    // Back-pressure on B and R channels.
    axi_write(A_OFF, 32'hCAFE_0001, 4'hF, 5);
    axi_read(A_OFF, d, 5); check("A after stalled write/read", d, 32'hCAFE_0001);

    // Unmapped offset.
    axi_write(X_OFF, 32'h5555_5555, 4'hF, 0);
    axi_read(X_OFF, d, 0); check("offset 0x14", d, 32'd0);

    // Reset mid-operation returns everything to reset values.
    axi_write(C_OFF, 32'd7, 4'hF, 0);
    @(posedge clk); #1 aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 aresetn = 1'b1;
    axi_read(A_OFF, d, 0); check("A after reset", d, 32'd0);
    axi_read(C_OFF, d, 0); check("CTRL after reset", d, 32'd0);
    axi_read(S_OFF, d, 0); check("STAT after reset", d, 32'd0);
    axi_read(R_OFF, d, 0); check("RES after reset", d, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

endmodule
